// File: rtl/rs_enc_seq.sv
// rs_enc_seq: sequencer for a systematic RS(N,K) GF(2^8) encoder. It drives an external LFSR divider.
// Optional macro RS_ENC_SHORTEN_EN: msg_eop on an accepted symbol ends the message early.
module rs_enc_seq #(
  parameter int N = 255,
  parameter int K = 239
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       msg_valid,
  input  logic [7:0] msg_data,
  input  logic       msg_eop,
  output logic       msg_ready,
  output logic [7:0] div_din,
  output logic       div_fb_en,
  output logic       div_en,
  output logic       div_clr,
  input  logic [7:0] par_data,
  output logic       code_valid,
  output logic [7:0] code_data,
  output logic       code_sop,
  output logic       code_eop,
  input  logic       out_ready,
  output logic       state_dbg
);
  localparam int P = N - K;
  localparam logic [7:0] LAST_MSG = 8'(K - 1);
  localparam logic [7:0] LAST_PAR = 8'(P - 1);

  typedef enum logic {ST_MSG = 1'b0, ST_PAR = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       code_valid_q, code_valid_d;
  logic [7:0] code_data_q, code_data_d;
  logic       code_sop_q, code_sop_d;
  logic       code_eop_q, code_eop_d;
  logic       adv, accept, msg_last;

  // Handshakes: a message symbol moves when msg_valid & msg_ready; a codeword symbol
  // moves when code_valid & out_ready, and code_* hold steady while valid and not ready.
  assign adv = out_ready | ~code_valid_q;

`ifdef RS_ENC_SHORTEN_EN
  assign msg_last = (cnt_q == LAST_MSG) | msg_eop;
`else
  logic unused_msg_eop;
  assign unused_msg_eop = msg_eop;
  assign msg_last = (cnt_q == LAST_MSG);
`endif

  always_comb begin
    msg_ready = 1'b0;
    accept    = 1'b0;
    div_din   = 8'h00;
    div_fb_en = 1'b0;
    div_en    = 1'b0;
    div_clr   = abort;
    if (state_q == ST_MSG) begin
      msg_ready = adv & ~abort;
      accept    = msg_ready & msg_valid;
      div_fb_en = 1'b1;
      div_en    = accept;
      div_din   = accept ? msg_data : 8'h00;
    end else begin
      // Zero input with feedback gated flushes the remainder out, top register first.
      div_en = adv & ~abort;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_valid_d = code_valid_q;
    code_data_d  = code_data_q;
    code_sop_d   = code_sop_q;
    code_eop_d   = code_eop_q;
    if (abort) begin
      state_d      = ST_MSG;
      cnt_d        = 8'd0;
      code_valid_d = 1'b0;
      code_sop_d   = 1'b0;
      code_eop_d   = 1'b0;
    end else if (state_q == ST_MSG) begin
      if (accept) begin
        code_data_d  = msg_data;
        code_sop_d   = (cnt_q == 8'd0);
        code_eop_d   = 1'b0;
        code_valid_d = 1'b1;
        cnt_d        = cnt_q + 8'd1;
        if (msg_last) begin
          cnt_d   = 8'd0;
          state_d = ST_PAR;
        end
      end else if (adv) begin
        code_valid_d = 1'b0;
      end
    end else if (adv) begin
      code_data_d  = par_data;
      code_valid_d = 1'b1;
      code_sop_d   = 1'b0;
      code_eop_d   = (cnt_q == LAST_PAR);
      cnt_d        = cnt_q + 8'd1;
      if (cnt_q == LAST_PAR) begin
        cnt_d   = 8'd0;
        state_d = ST_MSG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_MSG;
      cnt_q        <= 8'd0;
      code_valid_q <= 1'b0;
      code_data_q  <= 8'h00;
      code_sop_q   <= 1'b0;
      code_eop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_valid_q <= code_valid_d;
      code_data_q  <= code_data_d;
      code_sop_q   <= code_sop_d;
      code_eop_q   <= code_eop_d;
    end
  end

  assign code_valid = code_valid_q;
  assign code_data  = code_data_q;
  assign code_sop   = code_sop_q;
  assign code_eop   = code_eop_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rs_enc_seq.sv
// Bench for rs_enc_seq: models the LFSR divider it drives and checks codewords against long division.
// Shortened-codeword expectations follow the RS_ENC_SHORTEN_EN macro.
module tb_rs_enc_seq;
  localparam int N = 255;
  localparam int K = 239;
  localparam int P = N - K;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       msg_valid = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_eop = 1'b0;
  logic       msg_ready;
  logic [7:0] div_din;
  logic       div_fb_en, div_en, div_clr;
  logic [7:0] par_data;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_sop, code_eop;
  logic       out_ready = 1'b1;
  logic       state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic       rdy_mode = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [7:0] msg_buf [0:N-1];
  logic [7:0] gen [0:P];
  logic [7:0] par_exp [0:P-1];
  logic [7:0] rem [0:P-1];
  logic [7:0] fb;
  logic       gap_cv [0:7];
  logic       gap_den [0:7];
  int stall_cycles = 0, stall_den_err = 0, hold_err = 0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = '0;

  rs_enc_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_eop(msg_eop), .msg_ready(msg_ready),
    .div_din(div_din), .div_fb_en(div_fb_en), .div_en(div_en), .div_clr(div_clr),
    .par_data(par_data),
    .code_valid(code_valid), .code_data(code_data), .code_sop(code_sop), .code_eop(code_eop),
    .out_ready(out_ready), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a; y = b; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // Divider: remainder registers with generator taps, top register feeds par_data.
  assign fb = div_fb_en ? (div_din ^ rem[P-1]) : 8'h00;
  assign par_data = rem[P-1];
  always @(posedge clk) begin
    if (!rst_n || div_clr) begin
      for (int i = 0; i < P; i++) rem[i] <= 8'h00;
    end else if (div_en) begin
      rem[0] <= gmul(fb, gen[0]);
      for (int i = 1; i < P; i++) rem[i] <= rem[i-1] ^ gmul(fb, gen[i]);
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && !abort && (!code_valid || {code_sop, code_eop, code_data} !== prev_word))
        hold_err++;
      if (code_valid && out_ready) got_q.push_back({code_sop, code_eop, code_data});
      if (code_valid && !out_ready) begin
        stall_cycles++;
        if (div_en) stall_den_err++;
      end
      prev_stall = code_valid && !out_ready;
      prev_word  = {code_sop, code_eop, code_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic build_gen();
    logic [7:0] a;
    a = 8'h01;
    for (int j = 0; j <= P; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 0; i < P; i++) begin
      for (int j = P; j > 0; j--) gen[j] = gen[j-1] ^ gmul(gen[j], a);
      gen[0] = gmul(gen[0], a);
      a = gmul(a, 8'h02);
    end
  endtask

  // Reference parity by polynomial long division of m(x)*x^P by g(x).
  task automatic build_exp(input int len);
    logic [7:0] w [0:N+P];
    logic [7:0] c;
    for (int j = 0; j < len + P; j++) w[j] = (j < len) ? msg_buf[j] : 8'h00;
    for (int i = 0; i < len; i++) begin
      c = w[i];
      for (int j = 1; j <= P; j++) w[i+j] = w[i+j] ^ gmul(c, gen[P-j]);
    end
    for (int j = 0; j < P; j++) par_exp[j] = w[len+j];
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back({(i == 0), 1'b0, msg_buf[i]});
    for (int j = 0; j < P; j++) exp_q.push_back({1'b0, (j == P-1), par_exp[j]});
  endtask

  task automatic feed(input int len, input int eop_at, input int gap_after, input int gap_len);
    int i, guard, gap_left, rec;
    i = 0; guard = 0; gap_left = 0; rec = -1;
    while (i < len && guard < 5000) begin
      @(posedge clk); #2;
      guard++;
      if (gap_left > 0) begin
        msg_valid = 1'b0; msg_data = 8'h00; msg_eop = 1'b0;
      end else begin
        msg_valid = 1'b1; msg_data = msg_buf[i]; msg_eop = (i == eop_at);
      end
      @(negedge clk);
      if (rec >= 0 && rec <= gap_len) begin
        gap_cv[rec] = code_valid; gap_den[rec] = div_en; rec++;
      end
      if (gap_left > 0) gap_left--;
      else if (msg_ready) begin
        if (i == gap_after) begin gap_left = gap_len; rec = 0; end
        i++;
      end
    end
    @(posedge clk); #2;
    msg_valid = 1'b0; msg_data = 8'h00; msg_eop = 1'b0;
    if (guard >= 5000) begin
      vectors++; miscompares++;
      $display("FAIL feed_timeout accepted %0d required %0d", i, len);
    end
  endtask

  task automatic drain(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", code_valid); end
    vectors++; if (code_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got %h exp 00", code_data); end
    vectors++; if ({code_sop, code_eop} !== 2'b00) begin miscompares++; $display("FAIL rst_sop_eop got %b exp 00", {code_sop, code_eop}); end
    vectors++; if (state_dbg !== 1'b0) begin miscompares++; $display("FAIL rst_state got %b exp 0", state_dbg); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (msg_ready !== 1'b1) begin miscompares++; $display("FAIL rst_msg_ready got %b exp 1", msg_ready); end
    vectors++; if ({div_en, div_clr} !== 2'b00) begin miscompares++; $display("FAIL rst_div got %b exp 00", {div_en, div_clr}); end
  endtask

  task automatic test_full_codeword();
    int gapcnt;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(i + 1);
    build_exp(K);
    got_q.delete();
    feed(K, -1, -1, 0);
    gapcnt = 0;
    while (gapcnt < 100) begin
      @(negedge clk);
      if (msg_ready) break;
      gapcnt++;
    end
    vectors++; if (gapcnt !== P) begin miscompares++; $display("FAIL full_ready_gap got %0d exp %0d", gapcnt, P); end
    drain(N);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL full_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL full_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int den0, hold0, st0;
    den0 = stall_den_err; hold0 = hold_err; st0 = stall_cycles;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(i + 1);
    build_exp(K);
    got_q.delete();
    rdy_mode = 1'b1;
    feed(K, -1, -1, 0);
    drain(N);
    rdy_mode = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (stall_cycles - st0 < 20) begin miscompares++; $display("FAIL bp_stalls got %0d exp >=20", stall_cycles - st0); end
    vectors++; if (stall_den_err !== den0) begin miscompares++; $display("FAIL bp_div_en_on_stall got %0d exp %0d", stall_den_err, den0); end
    vectors++; if (hold_err !== hold0) begin miscompares++; $display("FAIL bp_hold got %0d exp %0d", hold_err, hold0); end
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL bp_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  task automatic test_input_gaps();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(i + 1);
    build_exp(K);
    got_q.delete();
    feed(K, -1, 100, 3);
    drain(N);
    vectors++; if (gap_cv[0] !== 1'b1) begin miscompares++; $display("FAIL gap_cv0 got %b exp 1", gap_cv[0]); end
    for (int g = 1; g <= 3; g++) begin
      vectors++; if (gap_cv[g] !== 1'b0) begin miscompares++; $display("FAIL gap_cv%0d got %b exp 0", g, gap_cv[g]); end
    end
    for (int g = 0; g < 3; g++) begin
      vectors++; if (gap_den[g] !== 1'b0) begin miscompares++; $display("FAIL gap_div_en%0d got %b exp 0", g, gap_den[g]); end
    end
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL gap_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL gap_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  task automatic test_abort();
    int guard;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(8'hA5 ^ 8'(i * 7));
    got_q.delete();
    feed(K, -1, -1, 0);
    guard = 0;
    while (got_q.size() < K + 5 && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    @(posedge clk); #2;
    abort = 1'b1;
    @(negedge clk);
    vectors++; if (div_clr !== 1'b1) begin miscompares++; $display("FAIL abort_clr got %b exp 1", div_clr); end
    vectors++; if (div_en !== 1'b0) begin miscompares++; $display("FAIL abort_div_en got %b exp 0", div_en); end
    vectors++; if (msg_ready !== 1'b0) begin miscompares++; $display("FAIL abort_msg_ready got %b exp 0", msg_ready); end
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    vectors++; if (code_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b exp 0", code_valid); end
    vectors++; if (div_clr !== 1'b0) begin miscompares++; $display("FAIL abort_clr_after got %b exp 0", div_clr); end
    vectors++; if (state_dbg !== 1'b0) begin miscompares++; $display("FAIL abort_state got %b exp 0", state_dbg); end
    for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
    build_exp(K);
    got_q.delete();
    feed(K, -1, -1, 0);
    drain(N);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL abort_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL abort_zero_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(8'h3C + 8'(i * 3));
    feed(50, -1, -1, 0);
    rst_n = 1'b0;
    @(posedge clk); #2;
    @(negedge clk);
    vectors++; if ({code_valid, code_sop, code_eop} !== 3'b000) begin miscompares++; $display("FAIL rstmid_flags got %b exp 000", {code_valid, code_sop, code_eop}); end
    vectors++; if (code_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_data got %h exp 00", code_data); end
    vectors++; if (state_dbg !== 1'b0) begin miscompares++; $display("FAIL rstmid_state got %b exp 0", state_dbg); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(i + 1);
    build_exp(K);
    got_q.delete();
    feed(K, -1, -1, 0);
    drain(N);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rstmid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL rstmid_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  task automatic test_shortened();
    int len;
    for (int i = 0; i < K; i++) msg_buf[i] = 8'(8'hF0 - 8'(i * 5));
`ifdef RS_ENC_SHORTEN_EN
    len = 20;
`else
    len = K;
`endif
    build_exp(len);
    got_q.delete();
    feed(len, 19, -1, 0);
    drain(len + P);
    vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL short_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      vectors++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        miscompares++;
        $display("FAIL short_sym[%0d] got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 10'h3FF, exp_q[j]);
      end
    end
  endtask

  initial begin
    build_gen();
    test_reset();
    test_full_codeword();
    test_backpressure();
    test_input_gaps();
    test_abort();
    test_reset_mid();
    test_shortened();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rs_enc_seq.md
# rs_enc_seq

Sequencer for the systematic Reed-Solomon encoder, GF(2^8) symbols. Sits directly upstream of the LFSR divider, the chain of 8-bit remainder registers with GF multipliers. It accepts message symbols, drives the divider's input, feedback gate and shift enable, and then emits the codeword: the K message symbols followed by the N-K parity symbols read from the divider's top remainder register. The output is registered, with valid/ready backpressure.

## Interface
- N, 255, codeword length in symbols (N ≤ 255).
- K, 239, message length in symbols (K < N); parity count P = N-K.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- abort  in  1  synchronous; discards the current codeword.
- msg_valid  in  1  message symbol present.
- msg_data  in  8  message symbol.
- msg_eop  in  1  last message symbol (used only with RS_ENC_SHORTEN_EN).
- msg_ready  out  1  symbol accepted when msg_valid & msg_ready.
- div_din  out  8  divider input symbol.
- div_fb_en  out  1  divider feedback gate.
- div_en  out  1  divider shift enable.
- div_clr  out  1  synchronous clear of remainder registers.
- par_data  in  8  highest-degree remainder register output.
- code_valid  out  1  output symbol valid.
- code_data  out  8  codeword symbol.
- code_sop  out  1  first symbol of the codeword.
- code_eop  out  1  last symbol of the codeword.
- out_ready  in  1  downstream accepts.

## Operation
- Two states, MSG and PAR, with an 8-bit counter cnt. Reset: state=MSG, cnt=0, code_valid=0, code_data=0, code_sop=0, code_eop=0.
- adv = out_ready | ~code_valid. When adv=0, all state holds and div_en=0.
- MSG:
  - msg_ready = adv.
  - On accept: div_din=msg_data, div_fb_en=1, div_en=1; code_data<=msg_data, code_sop<=(cnt==0), code_eop<=0, code_valid<=1; cnt++.
  - Accept of symbol K-1: cnt<=0, state<=PAR.
- MSG, no accept:
  - div_en=0, div_din=0.
  - If adv, code_valid<=0.
- PAR:
  - msg_ready=0, div_din=0, div_fb_en=0, div_en=adv.
  - Each adv cycle: code_data<=par_data, code_valid<=1, code_sop<=0; cnt++.
  - cnt==P-1: code_eop<=1, cnt<=0, state<=MSG.
  - With din=0 and feedback gated, the remainder registers reach zero after P shifts, so no clear is needed between codewords.
- abort:
  - Highest priority below rst_n.
  - div_clr=1 for that cycle, combinational from abort; div_en=0.
  - state<=MSG, cnt<=0, code_valid<=0, code_sop<=0, code_eop<=0.
  - msg_ready=0 in the abort cycle.
- div_clr=0 at all other times.
- rst_n low mid-codeword: same effect as the reset values above. The divider has its own reset.
- Simultaneous abort and msg_valid: the symbol is not accepted.

## Timing
- Combinational paths: msg_ready, div_* from state, adv, msg_valid and abort.
- Latency: accepted symbol to code_data is 1 cycle.
- par_data is sampled in the same cycle the divider shifts. The pre-shift top register is therefore output first, highest-degree parity first.
- Codeword throughput with out_ready=1 and no msg gaps: N symbols in N cycles. msg_ready is low for P cycles between codewords.
- Output holds stable while code_valid=1 and out_ready=0.

## Configuration
- RS_ENC_SHORTEN_EN defined:
  - msg_eop on an accepted MSG symbol ends the message early: cnt<=0, state<=PAR.
  - Output is a shortened codeword of (accepted count + P) symbols.
  - msg_eop on symbol K-1 behaves as normal.
- Undefined: msg_eop is ignored, and the message length is always K.

## Test plan
- **Full codeword.** Reset, out_ready=1, feed K=239 symbols 0x01..0xEF back-to-back. Expect 255 outputs: the first 239 echo the input, code_sop on symbol 0, and the 16 parity symbols match a golden LFSR model, with code_eop on the 255th.
- **Backpressure.** Toggle out_ready with a 50% random pattern during MSG and PAR. Expect no symbol lost or duplicated, div_en low on every stall cycle, and parity identical to the full-codeword case.
- **Input gaps.** Deassert msg_valid for 3 cycles after symbol 100. Expect code_valid low for 3 cycles, div_en=0 in those cycles, and the final codeword unchanged.
- **Abort mid-parity.** Pulse abort at parity symbol 5. Expect div_clr high for 1 cycle and code_valid=0 the next cycle. The next codeword of 239×0x00 must produce all-zero parity.
- **Reset mid-message.** Drop rst_n for 2 cycles at symbol 50. Expect all outputs at reset values. The next full codeword must be correct, with code_sop on its first symbol.
- **Shortened codeword (RS_ENC_SHORTEN_EN).** Assert msg_eop on symbol 19. Expect 20+16=36 outputs, with code_eop on output 35 and parity matching the golden model for a 20-symbol message. Without the macro, msg_eop is ignored and the output is 255 symbols.
